// File: rtl/count_pkg.sv
// Shared widths and the snapshot word type for the count snapshot FIFO.
package count_pkg;

  localparam int CW_DEF    = 4;
  localparam int EW_DEF    = 4;
  localparam int DEPTH_DEF = 4;
  localparam int SNAP_W    = EW_DEF + CW_DEF;

  // Snapshot word at the default widths: {epoch, count}
  typedef logic [SNAP_W-1:0] snap_t;

endpackage

// File: rtl/count_snapshot_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers and occupancy level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LW'(DEPTH));

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; the level says which entries are meaningful
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/count_snapshot_fifo.sv
// Captures {epoch, count} snapshots of a free-running counter on trig into a FIFO,
// extending the count with an epoch that advances on every all-ones-to-zero wrap.
module count_snapshot_fifo
  import count_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int EW    = EW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CW-1:0]            count_in,
  input  logic                     trig,
  output logic [EW+CW-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int W = EW + CW;

  logic [CW-1:0] prev_count_reg;
  logic [EW-1:0] epoch_reg, epoch_next;
  logic          ovf_reg, ovf_next;
  logic          wrap, full, empty, pop, push, overflow;
  logic [W-1:0]  wdata;

  // prev_count resets to zero, so a zero count right after reset is not a wrap
  assign wrap       = (prev_count_reg == {CW{1'b1}}) && (count_in == '0);
  assign epoch_next = epoch_reg + EW'(wrap);
  assign wdata      = {epoch_next, count_in};

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = trig && (!full || pop);
  assign overflow  = trig && full && !pop;

  // A fresh overflow wins over a clear in the same cycle
  assign ovf_next = overflow || (ovf_reg && !clr_ovf);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_count_reg <= '0;
      epoch_reg      <= '0;
      ovf_reg        <= 1'b0;
    end else begin
      prev_count_reg <= count_in;
      epoch_reg      <= epoch_next;
      ovf_reg        <= ovf_next;
    end
  end

  assign ovf = ovf_reg;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Scoreboard bench for count_snapshot_fifo: directed corner cases, then random traffic.
module tb_count_snapshot_fifo;
  import count_pkg::*;

  localparam int CW    = CW_DEF;
  localparam int EW    = EW_DEF;
  localparam int DEPTH = 4;
  localparam int W     = CW + EW;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic          trig = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [LW-1:0] level;
  logic          ovf;

  always #5 clk = ~clk;

  count_snapshot_fifo #(.CW(CW), .EW(EW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .trig      (trig),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  int    vectors = 0;
  int    miscompares = 0;
  snap_t exp_q[$];
  int    lvl_cur = 0, lvl_nxt = 0;
  bit    ovf_cur = 1'b0, ovf_nxt = 1'b0;
  int    epoch_m = 0, prev_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle from just after an edge; returns just after the next edge.
  task automatic step(input int c, input bit t, input bit r, input bit cl);
    bit pop_m, push_m;
    count_in  = CW'(c);
    trig      = t;
    out_ready = r;
    clr_ovf   = cl;
    if (prev_m == MAXC && c == 0) epoch_m = (epoch_m + 1) % (1 << EW);
    prev_m = c;
    pop_m  = (lvl_cur > 0) && r;
    push_m = t && ((lvl_cur < DEPTH) || pop_m);
    if (push_m) exp_q.push_back(snap_t'((epoch_m << CW) | c));
    lvl_nxt = lvl_cur + int'(push_m) - int'(pop_m);
    ovf_nxt = (t && !push_m) ? 1'b1 : (cl ? 1'b0 : ovf_cur);
    @(posedge clk); #1;
    lvl_cur = lvl_nxt;
    ovf_cur = ovf_nxt;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    trig = 1'b0;
    clr_ovf = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    lvl_cur = 0; lvl_nxt = 0;
    ovf_cur = 1'b0; ovf_nxt = 1'b0;
    epoch_m = 0; prev_m = 0;
    #1;
    check("rst_async_level", 32'(level), 0);
    check("rst_async_valid", 32'(out_valid), 0);
    check("rst_async_ovf", 32'(ovf), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    $display("reset pulse applied");
  endtask

  // Monitor: flags and level every cycle, head word on every accepted pop
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(lvl_cur != 0));
      check("level", 32'(level), 32'(lvl_cur));
      check("ovf", 32'(ovf), 32'(ovf_cur));
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got word %0h, expected none queued", out_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", 32'(out_data), 32'(e));
          $display("pop word=%02h expected=%02h level=%0d", out_data, e, level);
        end
      end
    end
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic capture into empty FIFO
    step(5, 1, 0, 0);
    check("basic_valid", 32'(out_valid), 1);
    check("basic_data", 32'(out_data), 32'h05);
    check("basic_level", 32'(level), 1);
    step(6, 0, 1, 0);
    check("basic_drained", 32'(level), 0);

    // Wraps advance the epoch, including the same-cycle wrap
    step(14, 0, 0, 0);
    step(15, 0, 0, 0);
    step(0, 1, 0, 0);
    check("wrap1_data", 32'(out_data), 32'h10);
    step(1, 0, 1, 0);
    step(15, 0, 0, 0);
    step(0, 1, 0, 0);
    check("wrap2_data", 32'(out_data), 32'h20);
    step(1, 0, 1, 0);
    check("wrap2_drained", 32'(level), 0);

    // Overflow: fifth word dropped, first four kept
    for (int i = 0; i < 5; i++) step(3 + i, 1, 0, 0);
    check("ovf_level", 32'(level), 4);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_head", 32'(out_data), 32'h23);
    step(8, 0, 0, 1);
    check("ovf_cleared", 32'(ovf), 0);

    // Full with push and pop together
    step(9, 1, 1, 0);
    check("fullpp_level", 32'(level), 4);
    check("fullpp_ovf", 32'(ovf), 0);
    check("fullpp_head", 32'(out_data), 32'h24);

    // Clear collides with a new overflow
    step(10, 1, 0, 1);
    check("collide_ovf", 32'(ovf), 1);

    // Mid-stream reset with three words held
    step(11, 0, 1, 0);
    check("pre_reset_level", 32'(level), 3);
    apply_reset();
    check("post_reset_valid", 32'(out_valid), 0);
    step(3, 1, 0, 0);
    check("post_reset_data", 32'(out_data), 32'h03);

    // Random traffic against the model
    cnt = 4;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        apply_reset();
      end else begin
        if ($urandom_range(0, 15) == 0) cnt = $urandom_range(0, MAXC);
        else cnt = (cnt + 1) % (MAXC + 1);
        step(cnt, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
             $urandom_range(0, 7) == 0);
      end
    end

    for (int k = 0; k < DEPTH + 2; k++) begin
      cnt = (cnt + 1) % (MAXC + 1);
      step(cnt, 0, 1, 0);
    end
    check("final_level", 32'(level), 0);
    check("final_queue", 32'(exp_q.size()), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_snapshot_fifo.md
COUNT_SNAPSHOT_FIFO -- requirements
Module: count_snapshot_fifo

Interface
REQ-001 The block SHALL have parameter CW, default 4, meaning the width of the incoming count.
REQ-002 The block SHALL have parameter EW, default 4, meaning the width of the wrap (epoch) counter.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of 2, at least 2).
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all logic is clocked on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port count_in, input, CW bits, the free-running up-counter value from the upstream stage.
REQ-007 The block SHALL have port trig, input, 1 bit, a capture request sampled each cycle.
REQ-008 The block SHALL have port out_data, output, EW+CW bits, carrying the snapshot word {epoch, count}.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the consumer accept signal.
REQ-011 The block SHALL have port level, output, log2(DEPTH)+1 bits, giving the current FIFO occupancy.
REQ-012 The block SHALL have port ovf, output, 1 bit, a sticky overflow flag.
REQ-013 The block SHALL have port clr_ovf, input, 1 bit, a synchronous clear for ovf.

Function
REQ-014 The block SHALL register count_in every cycle as prev_count.
REQ-015 The block SHALL detect a wrap when prev_count equals all-ones and count_in equals zero; epoch SHALL then increment modulo 2^EW.
REQ-016 The capture word SHALL be {epoch_next, count_in}, where epoch_next includes any wrap detected in the same cycle.
REQ-017 Push SHALL occur when trig=1 and the FIFO is not full, or when trig=1, the FIFO is full and a pop occurs in the same cycle.
REQ-018 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 The output SHALL be show-ahead: out_valid = (level != 0), and out_data = the head entry with no extra read cycle.
REQ-020 Latency SHALL be as follows: trig in cycle N into an empty FIFO gives out_valid=1 with that word from cycle N+1.
REQ-021 Simultaneous push and pop SHALL leave level unchanged, and both operations SHALL complete.
REQ-022 Push on empty with out_ready=1 SHALL NOT bypass; the word appears at N+1.
REQ-023 trig while full without a pop SHALL drop the word and set ovf=1 from the next cycle; FIFO contents SHALL be unchanged.
REQ-024 ovf SHALL stay 1 until a cycle with clr_ovf=1 and no new overflow; clr_ovf and an overflow in the same cycle SHALL leave ovf=1.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range from 0 to DEPTH.
REQ-026 out_data SHALL be don't-care when out_valid=0; the bench SHALL NOT check it then.

Reset
REQ-027 While rst=0, the block SHALL immediately force level=0, out_valid=0, ovf=0, epoch=0, prev_count=0, and both pointers to 0.
REQ-028 Because prev_count resets to 0, a count_in of 0 right after reset SHALL NOT count as a wrap.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the first push after deassertion SHALL capture from the current epoch 0.
REQ-030 FIFO storage SHALL NOT require reset.

Structure
REQ-031 Package count_pkg SHALL hold the CW and EW defaults and the snapshot word type of width EW+CW.
REQ-032 The storage, pointers and level logic SHALL be a sub-module named sync_fifo (parameters WIDTH and DEPTH), instantiated once.
REQ-033 Wrap detection, epoch and overflow logic SHALL reside in the top module count_snapshot_fifo.

Verification
REQ-034 Basic capture: with count_in=5, epoch=0, trig pulse, and out_ready=0 → next cycle out_valid=1, out_data=8'h05, level=1.
REQ-035 Wrap: drive count_in 14, 15, 0 with trig on the 0 cycle → out_data=8'h10; a further 15→0 step → epoch=2.
REQ-036 Overflow: 5 trig pulses with out_ready=0 (DEPTH=4) → level=4, ovf=1, and the first four words are intact in order; a later clr_ovf pulse → ovf=0.
REQ-037 Full with simultaneous push/pop: level=4 with trig=1 and out_ready=1 → level stays 4, ovf stays 0, and the oldest word leaves.
REQ-038 Clear/overflow collision: clr_ovf=1 in the same cycle as an overflow → ovf=1 next cycle.
REQ-039 Mid-stream reset: rst low for 1 cycle with level=3 → level=0, out_valid=0, and the next capture has epoch field 0.
